// File: rtl/fp_special_classifier_pipe.sv
// fp_special_classifier_pipe
//   Registered IEEE-754 operand classifier for the FP multiplier datapath.
//   Classifies operands a/b as zero/denormal/normal/inf/NaN, predicts the
//   special-case result of a*b, and presents it through a one-deep
//   valid/ready output stage. Also keeps sticky exception flags and a
//   saturating count of invalid-operation pairs.
//
//   Optional feature macro: FP_CLASS_SNAN_EN
//     defined   : NaN with man MSB == 0 is signaling and marks the pair invalid
//     undefined : all NaNs are quiet, only zero*inf is invalid
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      operand handshake (in_ready = !out_valid || out_ready)
//   a, b                     operands {sign, exp[EXP_W], man[MAN_W]}
//   out_valid / out_ready    result handshake
//   out_a_class, out_b_class one-hot {nan, inf, denormal, normal, zero}
//   out_sign                 a.sign ^ b.sign
//   out_res_special          result code is not "none"
//   out_res_code             00 none, 01 zero, 10 inf, 11 NaN
//   out_invalid              invalid operation for this pair
//   flags_clr                synchronous clear of sticky flags and counter
//   sticky_flags             {invalid, nan_seen, inf_seen, denormal_seen}
//   invalid_cnt              saturating count of accepted invalid pairs
module fp_special_classifier_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_a_class,
  output logic [4:0]             out_b_class,
  output logic                   out_sign,
  output logic                   out_res_special,
  output logic [1:0]             out_res_code,
  output logic                   out_invalid,
  input  logic                   flags_clr,
  output logic [3:0]             sticky_flags,
  output logic [CNT_W-1:0]       invalid_cnt
);

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_ZERO = 2'b01,
    RES_INF  = 2'b10,
    RES_NAN  = 2'b11
  } res_code_e;

  // One-hot class {nan, inf, denormal, normal, zero}
  function automatic logic [4:0] classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
    logic man_nz;
    man_nz = |m;
    if (e == '0)      classify = man_nz ? 5'b00100 : 5'b00001;
    else if (e == '1) classify = man_nz ? 5'b10000 : 5'b01000;
    else              classify = 5'b00010;
  endfunction

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic [4:0]       a_cls, b_cls;
  logic             any_nan, any_inf, any_zero, any_den, zero_inf;
  logic             pair_invalid;
  res_code_e        pair_code;
  logic             accept;

  logic             valid_q, valid_d;
  logic [4:0]       a_cls_q, a_cls_d, b_cls_q, b_cls_d;
  logic             sign_q, sign_d;
  res_code_e        code_q, code_d;
  logic             inv_q, inv_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign a_exp = a[EXP_W+MAN_W-1:MAN_W];
  assign b_exp = b[EXP_W+MAN_W-1:MAN_W];
  assign a_man = a[MAN_W-1:0];
  assign b_man = b[MAN_W-1:0];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_cls    = classify(a_exp, a_man);
    b_cls    = classify(b_exp, b_man);
    any_nan  = a_cls[4] | b_cls[4];
    any_inf  = a_cls[3] | b_cls[3];
    any_den  = a_cls[2] | b_cls[2];
    any_zero = a_cls[0] | b_cls[0];
    zero_inf = (a_cls[0] & b_cls[3]) | (a_cls[3] & b_cls[0]);

    if (any_nan || zero_inf) pair_code = RES_NAN;
    else if (any_inf)        pair_code = RES_INF;
    else if (any_zero)       pair_code = RES_ZERO;
    else                     pair_code = RES_NONE;

`ifdef FP_CLASS_SNAN_EN
    pair_invalid = zero_inf
                 | (a_cls[4] & ~a_man[MAN_W-1])
                 | (b_cls[4] & ~b_man[MAN_W-1]);
`else
    pair_invalid = zero_inf;
`endif
  end

  always_comb begin
    valid_d  = valid_q;
    a_cls_d  = a_cls_q;
    b_cls_d  = b_cls_q;
    sign_d   = sign_q;
    code_d   = code_q;
    inv_d    = inv_q;

    if (accept) begin
      valid_d = 1'b1;
      a_cls_d = a_cls;
      b_cls_d = b_cls;
      sign_d  = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      code_d  = pair_code;
      inv_d   = pair_invalid;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    // Clear takes effect first so a same-cycle accept still lands its bits.
    sticky_d = flags_clr ? '0 : sticky_q;
    cnt_d    = flags_clr ? '0 : cnt_q;
    if (accept) begin
      sticky_d = sticky_d | {pair_invalid, any_nan, any_inf, any_den};
      if (pair_invalid && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      a_cls_q  <= '0;
      b_cls_q  <= '0;
      sign_q   <= 1'b0;
      code_q   <= RES_NONE;
      inv_q    <= 1'b0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      a_cls_q  <= a_cls_d;
      b_cls_q  <= b_cls_d;
      sign_q   <= sign_d;
      code_q   <= code_d;
      inv_q    <= inv_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_a_class     = a_cls_q;
  assign out_b_class     = b_cls_q;
  assign out_sign        = sign_q;
  assign out_res_code    = code_q;
  assign out_res_special = (code_q != RES_NONE);
  assign out_invalid     = inv_q;
  assign sticky_flags    = sticky_q;
  assign invalid_cnt     = cnt_q;

endmodule

// File: tb/tb_fp_special_classifier_pipe.sv
// Testbench for fp_special_classifier_pipe (EXP_W=8, MAN_W=23, CNT_W=8).
// Expected results are queued on every accepted pair and checked when the
// DUT transfers them; sticky flags and the counter follow a reference model.
module tb_fp_special_classifier_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_a_class, out_b_class;
  logic        out_sign, out_res_special, out_invalid;
  logic [1:0]  out_res_code;
  logic        flags_clr = 1'b0;
  logic [3:0]  sticky_flags;
  logic [7:0]  invalid_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] ac;
    logic [4:0] bc;
    logic       sign;
    logic [1:0] code;
    logic       inv;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_sticky = '0;
  logic [7:0] m_cnt    = '0;

  fp_special_classifier_pipe #(
    .EXP_W(8),
    .MAN_W(23),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a_class(out_a_class),
    .out_b_class(out_b_class),
    .out_sign(out_sign),
    .out_res_special(out_res_special),
    .out_res_code(out_res_code),
    .out_invalid(out_invalid),
    .flags_clr(flags_clr),
    .sticky_flags(sticky_flags),
    .invalid_cnt(invalid_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] m_cls(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'hFF) return (m != 0) ? 5'b10000 : 5'b01000;
    if (e == 8'h00) return (m != 0) ? 5'b00100 : 5'b00001;
    return 5'b00010;
  endfunction

  function automatic logic m_snan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0) && !x[22];
  endfunction

  function automatic exp_t m_res(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    logic zi;
    r.ac   = m_cls(x);
    r.bc   = m_cls(y);
    r.sign = x[31] ^ y[31];
    zi = (r.ac == 5'b00001 && r.bc == 5'b01000) || (r.ac == 5'b01000 && r.bc == 5'b00001);
    if (r.ac == 5'b10000 || r.bc == 5'b10000 || zi) r.code = 2'b11;
    else if (r.ac == 5'b01000 || r.bc == 5'b01000)  r.code = 2'b10;
    else if (r.ac == 5'b00001 || r.bc == 5'b00001)  r.code = 2'b01;
    else                                            r.code = 2'b00;
`ifdef FP_CLASS_SNAN_EN
    r.inv = zi || m_snan(x) || m_snan(y);
`else
    r.inv = zi;
`endif
    return r;
  endfunction

  // Scoreboard / reference model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e, r;
    if (rst) begin
      sb.delete();
      m_sticky = '0;
      m_cnt    = '0;
    end else begin
      total++;
      if (sticky_flags !== m_sticky) begin
        bad++;
        $display("FAIL sticky_model got=%b want=%b t=%0t", sticky_flags, m_sticky, $time);
      end
      total++;
      if (invalid_cnt !== m_cnt) begin
        bad++;
        $display("FAIL cnt_model got=%0d want=%0d t=%0t", invalid_cnt, m_cnt, $time);
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=valid want=empty t=%0t", $time);
        end else begin
          e = sb.pop_front();
          if ({out_a_class, out_b_class, out_sign, out_res_code, out_invalid, out_res_special}
              !== {e.ac, e.bc, e.sign, e.code, e.inv, (e.code != 2'b00)}) begin
            bad++;
            $display("FAIL result got=%b_%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b_%b t=%0t",
                     out_a_class, out_b_class, out_sign, out_res_code, out_invalid, out_res_special,
                     e.ac, e.bc, e.sign, e.code, e.inv, (e.code != 2'b00), $time);
          end
        end
      end
      if (flags_clr) begin
        m_sticky = '0;
        m_cnt    = '0;
      end
      if (in_valid && in_ready) begin
        r = m_res(a, b);
        sb.push_back(r);
        m_sticky = m_sticky | {r.inv,
                               (r.ac[4] | r.bc[4]),
                               (r.ac[3] | r.bc[3]),
                               (r.ac[2] | r.bc[2])};
        if (r.inv && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flags_clr = 1'b0;
  endtask

  task automatic clear_flags();
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_a_class, out_b_class, out_sign, out_res_code, out_invalid,
         out_res_special, sticky_flags, invalid_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b%b%b%b%b%b%b%b%h want=0", out_valid, out_a_class,
               out_b_class, out_sign, out_res_code, out_invalid, out_res_special,
               sticky_flags, invalid_cnt);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    send(32'h3F80_0000, 32'h4000_0000);
    total++;
    if ({out_valid, out_a_class, out_b_class, out_res_code, out_sign, out_invalid, out_res_special}
        !== {1'b1, 5'b00010, 5'b00010, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL normal_pair got=%b_%b_%b_%b_%b_%b_%b want=1_00010_00010_00_0_0_0",
               out_valid, out_a_class, out_b_class, out_res_code, out_sign, out_invalid,
               out_res_special);
    end
  endtask

  task automatic test_zero_inf();
    clear_flags();
    send(32'h0000_0000, 32'hFF80_0000);
    total++;
    if ({out_a_class, out_b_class, out_res_code, out_sign, out_invalid, sticky_flags, invalid_cnt}
        !== {5'b00001, 5'b01000, 2'b11, 1'b1, 1'b1, 4'b1010, 8'd1}) begin
      bad++;
      $display("FAIL zero_inf got=%b_%b_%b_%b_%b_%b_%0d want=00001_01000_11_1_1_1010_1",
               out_a_class, out_b_class, out_res_code, out_sign, out_invalid, sticky_flags,
               invalid_cnt);
    end
  endtask

  task automatic test_den_qnan();
    clear_flags();
    send(32'h0000_0001, 32'h7FC0_0000);
    total++;
    if ({out_a_class, out_b_class, out_res_code, out_invalid, sticky_flags}
        !== {5'b00100, 5'b10000, 2'b11, 1'b0, 4'b0101}) begin
      bad++;
      $display("FAIL den_qnan got=%b_%b_%b_%b_%b want=00100_10000_11_0_0101",
               out_a_class, out_b_class, out_res_code, out_invalid, sticky_flags);
    end
    // Denormal times normal is not special; inf times normal is inf.
    send(32'h0000_0010, 32'hC000_0000);
    total++;
    if ({out_res_code, out_res_special} !== 3'b000) begin
      bad++;
      $display("FAIL den_norm got=%b want=000", {out_res_code, out_res_special});
    end
    send(32'h7F80_0000, 32'h3F80_0000);
    total++;
    if ({out_res_code, out_res_special} !== 3'b101) begin
      bad++;
      $display("FAIL inf_norm got=%b want=101", {out_res_code, out_res_special});
    end
    send(32'h8000_0000, 32'h0012_3456);
    total++;
    if ({out_res_code, out_sign} !== 3'b011) begin
      bad++;
      $display("FAIL zero_den got=%b want=011", {out_res_code, out_sign});
    end
  endtask

  task automatic test_snan();
    logic [7:0] c0;
    logic       want_inv;
`ifdef FP_CLASS_SNAN_EN
    want_inv = 1'b1;
`else
    want_inv = 1'b0;
`endif
    c0 = m_cnt;
    send(32'h3F80_0000, 32'h7F80_0001);
    total++;
    if ({out_res_code, out_invalid, invalid_cnt} !== {2'b11, want_inv, c0 + {7'd0, want_inv}}) begin
      bad++;
      $display("FAIL snan got=%b_%b_%0d want=11_%b_%0d", out_res_code, out_invalid, invalid_cnt,
               want_inv, c0 + {7'd0, want_inv});
    end
  endtask

  task automatic test_stall();
    logic [12:0] snap;
    out_ready = 1'b0;
    send(32'h0000_0000, 32'h7F80_0000);
    a = 32'h4040_0000;
    b = 32'hBF80_0000;
    in_valid = 1'b1;
    snap = {out_valid, out_a_class, out_b_class, out_res_code};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, out_a_class, out_b_class, out_res_code} !== {1'b0, snap}) begin
        bad++;
        $display("FAIL stall_hold got=%b_%b want=0_%b", in_ready,
                 {out_valid, out_a_class, out_b_class, out_res_code}, snap);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_a_class, out_b_class, out_sign, out_res_code} !== {1'b1, 5'b00010, 5'b00010, 1'b1, 2'b00}) begin
      bad++;
      $display("FAIL stall_release got=%b_%b_%b_%b_%b want=1_00010_00010_1_00",
               out_valid, out_a_class, out_b_class, out_sign, out_res_code);
    end
  endtask

  task automatic test_clr_accept();
    send(32'h7FC0_0000, 32'h0000_0000);
    send(32'h0000_0000, 32'h7F80_0000);
    send(32'h0000_0003, 32'hFF80_0000);
    flags_clr = 1'b1;
    send(32'hFF80_0000, 32'h8000_0000);
    total++;
    if ({sticky_flags, invalid_cnt} !== {4'b1010, 8'd1}) begin
      bad++;
      $display("FAIL clr_accept got=%b_%0d want=1010_1", sticky_flags, invalid_cnt);
    end
  endtask

  task automatic test_back_to_back_saturate();
    clear_flags();
    for (int i = 0; i < 256; i++) begin
      a = i[0] ? 32'h7F80_0000 : 32'h0000_0000;
      b = i[0] ? 32'h8000_0000 : 32'hFF80_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++;
    if (invalid_cnt !== 8'd255) begin
      bad++;
      $display("FAIL cnt_saturate got=%0d want=255", invalid_cnt);
    end
    send(32'h0000_0000, 32'h7F80_0000);
    total++;
    if (invalid_cnt !== 8'd255) begin
      bad++;
      $display("FAIL cnt_no_wrap got=%0d want=255", invalid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h0000_0000, 32'h7F80_0000);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_a_class, out_b_class, out_sign, out_res_code, out_invalid,
         out_res_special, sticky_flags, invalid_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_mid got=%b_%b_%b_%b_%b_%b_%b_%b_%0d want=0", out_valid, out_a_class,
               out_b_class, out_sign, out_res_code, out_invalid, out_res_special,
               sticky_flags, invalid_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_mid_ready got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", sb.size());
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    @(posedge clk);
    #1;
    test_basic();
    test_zero_inf();
    test_den_qnan();
    test_snan();
    test_stall();
    test_clr_accept();
    test_back_to_back_saturate();
    drain();
    test_reset_mid();
    send(32'h4000_0000, 32'h4040_0000);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
